// File: rtl/subtractor_seq.sv
// rtl/subtractor_seq.sv - chunk-serial two's-complement subtractor d = a - b - bi
module subtractor_seq #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bo,
    output logic         ovf
);

    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-1:0]   d_q;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic           bo_q;
    logic           ovf_q;
    logic           in_ready_q;
    logic           out_valid_q;

    // The operand registers shift right by one chunk per RUN cycle, so the
    // chunk being processed is always the low W bits and no wide mux is needed.
    logic [W-1:0]   a_k;
    logic [W-1:0]   b_k;
    logic [W-1:0]   s;
    logic           c_out;
    logic           last_chunk;
    logic [N-1:0]   d_d;
    logic           ovf_d;

    // One chunk of a + ~b + carry, plus the difference register with the new chunk shifted in at the top.
    always_comb begin
        a_k            = a_q[W-1:0];
        b_k            = b_q[W-1:0];
        {c_out, s}     = {1'b0, a_k} + {1'b0, ~b_k} + {{W{1'b0}}, carry_q};
        last_chunk     = (cnt_q == CW'(K - 1));
        // After K shifts every chunk lands at its own position d[k*W +: W].
        d_d            = d_q >> W;
        d_d[N-1 -: W]  = s;
        // On the last chunk a_k/b_k hold the original top bits, so a_k[W-1]
        // is the operand sign bit a[N-1].
        ovf_d          = (a_k[W-1] != b_k[W-1]) && (s[W-1] != a_k[W-1]);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            bo_q        <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        // Subtraction as a + ~b + 1; a borrow-in removes the +1.
                        carry_q    <= ~bi;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> W;
                    b_q     <= b_q >> W;
                    d_q     <= d_d;
                    carry_q <= c_out;
                    if (last_chunk) begin
                        // A missing carry out of the top chunk means a borrow.
                        bo_q        <= ~c_out;
                        ovf_q       <= ovf_d;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    // Inputs are not sampled here, which leaves one bubble cycle before the next accept.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bo        = bo_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_subtractor_seq.sv
// tb/tb_subtractor_seq.sv - scoreboard bench for subtractor_seq
module tb_subtractor_seq;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int sweep_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [65:0] ref_sub(input int n, input logic [63:0] av,
                                            input logic [63:0] bv, input logic biv);
        longint sa, sb, diff, lim;
        logic [63:0] dv;
        logic bov, ovv;
        lim  = longint'(1) << (n - 1);
        sa   = av[n-1] ? longint'(av) - 2 * lim : longint'(av);
        sb   = bv[n-1] ? longint'(bv) - 2 * lim : longint'(bv);
        diff = sa - sb - longint'({63'd0, biv});
        ovv  = (diff < -lim) || (diff >= lim);
        bov  = av < (bv + {63'd0, biv});
        dv   = (av - bv - {63'd0, biv}) & ((64'd1 << n) - 64'd1);
        return {ovv, bov, dv};
    endfunction

    // ---------------- main instance: N=16, W=4, directed ----------------
    logic        m_rst_n = 1'b0;
    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic        m_bi = 1'b0;
    logic        m_out_valid;
    logic        m_out_ready = 1'b1;
    logic [15:0] m_d;
    logic        m_bo;
    logic        m_ovf;
    exp_t        m_q[$];
    logic        m_prev_ov = 1'b0;
    logic        m_prev_rdy = 1'b0;
    logic [17:0] m_hold = '0;

    subtractor_seq #(.N(16), .W(4)) u_main (
        .clk(clk), .rst_n(m_rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .bi(m_bi), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .d(m_d), .bo(m_bo), .ovf(m_ovf)
    );

    always @(negedge clk) begin
        if (m_rst_n) begin
            if (m_prev_ov && !m_prev_rdy) begin
                check("main_hold_valid", m_out_valid, 1);
                check("main_hold_result", {m_d, m_bo, m_ovf}, m_hold);
            end
            if (m_out_valid) begin
                check("main_in_ready_low_done", m_in_ready, 0);
                if (m_q.size() == 0) begin
                    check("main_spurious_out", 1, 0);
                end else begin
                    if (!m_prev_ov) check("main_latency", cyc - m_q[0].acc, 4);
                    if (m_out_ready) begin
                        exp_t e;
                        e = m_q.pop_front();
                        check("main_d", m_d, e.d);
                        check("main_bo", m_bo, e.bo);
                        check("main_ovf", m_ovf, e.ovf);
                    end
                end
            end
        end
        m_prev_ov  = m_out_valid && m_rst_n;
        m_prev_rdy = m_out_ready;
        m_hold     = {m_d, m_bo, m_ovf};
    end

    task automatic m_issue(input logic [15:0] av, input logic [15:0] bv, input logic biv,
                           input logic [15:0] ed, input logic ebo, input logic eovf,
                           output int acc);
        exp_t e;
        bit   ok = 1'b0;
        acc = -1;
        m_a = av; m_b = bv; m_bi = biv; m_in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (m_in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            check("main_accept_timeout", 0, 1);
            m_in_valid = 1'b0;
        end else begin
            e.d = {48'd0, ed}; e.bo = ebo; e.ovf = eovf; e.acc = cyc + 1;
            acc = cyc + 1;
            m_q.push_back(e);
            @(posedge clk); #1;
            m_in_valid = 1'b0;
            m_a = 16'($urandom); m_b = 16'($urandom); m_bi = 1'($urandom);
        end
    endtask

    task automatic m_drain();
        for (int t = 0; t < 200 && m_q.size() != 0; t++) @(negedge clk);
        if (m_q.size() != 0) check("main_drain_timeout", m_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // ---------------- parameter sweep instances, random ----------------
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int SN = (gi == 2) ? 32 : 8;
        localparam int SW = (gi == 0) ? 1 : ((gi == 1) ? 8 : 4);
        localparam int SK = SN / SW;

        logic          rst_n = 1'b0;
        logic          in_valid = 1'b0;
        logic          in_ready;
        logic [SN-1:0] a = '0;
        logic [SN-1:0] b = '0;
        logic          bi = 1'b0;
        logic          out_valid;
        logic          out_ready = 1'b1;
        logic [SN-1:0] d;
        logic          bo;
        logic          ovf;
        exp_t          q[$];
        logic          prev_ov = 1'b0;
        logic          prev_rdy = 1'b0;
        logic [SN+1:0] hold = '0;

        subtractor_seq #(.N(SN), .W(SW)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
            .d(d), .bo(bo), .ovf(ovf)
        );

        initial begin : drv
            logic [63:0] ra, rb, mask;
            logic        rbi;
            logic [65:0] r;
            exp_t        e;
            bit          ok;
            mask = (64'd1 << SN) - 64'd1;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            for (int k = 0; k < 1000; k++) begin
                ra  = {32'($urandom), 32'($urandom)} & mask;
                rb  = {32'($urandom), 32'($urandom)} & mask;
                rbi = 1'($urandom);
                case ($urandom_range(0, 7))
                    0: rb = ra;
                    1: rb = 64'd0;
                    2: begin ra = 64'd0; rb = mask; end
                    default: ;
                endcase
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                a = ra[SN-1:0]; b = rb[SN-1:0]; bi = rbi; in_valid = 1'b1;
                ok = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (in_ready) begin
                        ok = 1'b1;
                        break;
                    end
                    @(posedge clk); #1;
                end
                if (!ok) begin
                    check($sformatf("sweep%0d_accept_timeout", gi), 0, 1);
                    break;
                end
                r = ref_sub(SN, ra, rb, rbi);
                e.d = r[63:0]; e.bo = r[64]; e.ovf = r[65]; e.acc = cyc + 1;
                q.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                a = SN'($urandom); b = SN'($urandom); bi = 1'($urandom);
            end
            for (int t = 0; t < 500 && q.size() != 0; t++) @(negedge clk);
            if (q.size() != 0) check($sformatf("sweep%0d_drain_timeout", gi), q.size(), 0);
            sweep_done++;
        end

        initial begin : bp
            forever begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                if (prev_ov && !prev_rdy) begin
                    check($sformatf("sweep%0d_hold_valid", gi), out_valid, 1);
                    check($sformatf("sweep%0d_hold_result", gi), {d, bo, ovf}, hold);
                end
                if (out_valid) begin
                    check($sformatf("sweep%0d_in_ready_low_done", gi), in_ready, 0);
                    if (q.size() == 0) begin
                        check($sformatf("sweep%0d_spurious_out", gi), 1, 0);
                    end else begin
                        if (!prev_ov) check($sformatf("sweep%0d_latency", gi), cyc - q[0].acc, SK);
                        if (out_ready) begin
                            exp_t e;
                            e = q.pop_front();
                            check($sformatf("sweep%0d_d", gi), d, e.d);
                            check($sformatf("sweep%0d_bo", gi), bo, e.bo);
                            check($sformatf("sweep%0d_ovf", gi), ovf, e.ovf);
                        end
                    end
                end
            end
            prev_ov  = out_valid && rst_n;
            prev_rdy = out_ready;
            hold     = {d, bo, ovf};
        end
    end

    // ---------------- directed sequence and summary ----------------
    initial begin : main_seq
        int acc1, acc2, acc3;
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", m_in_ready, 1);
        check("reset_out_valid", m_out_valid, 0);
        check("reset_d", m_d, 0);
        check("reset_bo", m_bo, 0);
        check("reset_ovf", m_ovf, 0);
        m_rst_n = 1'b1;
        @(posedge clk); #1;

        m_issue(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, acc1); m_drain();
        m_issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, acc1); m_drain();
        m_issue(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, acc1); m_drain();
        m_issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, acc1); m_drain();
        m_issue(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, acc1); m_drain();

        // Backpressure: result must hold for 10 cycles with in_ready low.
        m_out_ready = 1'b0;
        m_issue(16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0, acc1);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (m_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("bp_valid_timeout", 0, 1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        m_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_after", m_in_ready, 1);
        check("bp_out_valid_after", m_out_valid, 0);
        @(posedge clk); #1;

        // Back-to-back issue spacing is K+2.
        m_issue(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, acc1);
        m_issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, acc2);
        check("issue_spacing", acc2 - acc1, 6);
        m_drain();

        // Reset in the second RUN cycle aborts the operation.
        m_issue(16'h1111, 16'h2222, 1'b0, 16'hEEEF, 1'b1, 1'b0, acc3);
        @(posedge clk); #1;
        m_rst_n = 1'b0;
        #1;
        check("abort_out_valid", m_out_valid, 0);
        check("abort_in_ready", m_in_ready, 1);
        check("abort_d", m_d, 0);
        void'(m_q.pop_back());
        repeat (2) @(posedge clk);
        #1 m_rst_n = 1'b1;
        @(posedge clk); #1;
        m_issue(16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0, acc1); m_drain();

        for (int t = 0; t < 60000 && sweep_done < 3; t++) @(posedge clk);
        if (sweep_done < 3) check("sweep_timeout", sweep_done, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/subtractor_seq.md
Name: subtractor_seq

Overview:
- Multi-cycle, chunk-serial two's-complement subtractor computing d = a - b - bi.
- It is the inverse-direction companion of the team's combinational carry-lookahead adder.
- It processes W bits per cycle, trading latency for area in datapaths that already handshake (accumulators, address/offset units).
- Operands enter and results leave over valid/ready handshakes.

Parameters:
- N, 16, operand/result width in bits. Legal when N >= 1.
- W, 4, bits processed per RUN cycle. Legal when 1 <= W <= N and N % W == 0.
- Derived: K = N/W, the number of RUN cycles per operation.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, bi are presented.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend.
- b  input  N  subtrahend.
- bi  input  1  borrow in.
- out_valid  output  1  result d, bo, ovf is valid.
- out_ready  input  1  consumer accepts the result.
- d  output  N  difference a - b - bi, modulo 2^N.
- bo  output  1  borrow out. 1 when unsigned a < b + bi.
- ovf  output  1  signed overflow of the two's-complement subtraction.

Behaviour:
- Reset (async assert on rst_n low, sync release): state=IDLE, in_ready=1, out_valid=0, d=0, bo=0, ovf=0, chunk counter=0, operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: capture a, b, bi; set carry register = ~bi; counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle processes chunk k = counter, bits [k*W +: W].
  - The chunk computes {c_out, s} = a_k + ~b_k + carry; s is written into d[k*W +: W]; carry <= c_out; counter increments.
  - On the cycle processing k = K-1:
    - bo <= ~c_out.
    - ovf <= (a[N-1] != b[N-1]) && (s[W-1] != a[N-1]).
    - Go to DONE.
- DONE:
  - out_valid=1; d, bo, ovf held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle.
  - No input acceptance in DONE, so there is one bubble cycle between operations.
- Latency: out_valid rises exactly K cycles after the acceptance edge. Minimum issue interval is K+2 cycles.
- W == N: K=1, so RUN lasts one cycle.
- d, bo, ovf are registered outputs. Their values while out_valid=0 are don't-care but deterministic; they hold the previous or partial result.
- Inputs a, b, bi are ignored except at the acceptance edge; changing them during RUN or DONE has no effect.
- in_valid asserted during RUN/DONE is not accepted. The producer must hold it until in_ready.
- Reset asserted in any state aborts the operation immediately and returns all outputs to reset values. No partial result is ever presented.
- Counter width is $clog2(K) with a minimum of 1 bit. The counter never wraps inside RUN.
- Arithmetic matches a - b - bi over N bits exactly for all operands, including a=b, b=0, and a=0 with b=2^N-1.

Test Plan:
- N=16, W=4; a=0x1234, b=0x0034, bi=0 -> out_valid 4 cycles after accept; d=0x1200, bo=0, ovf=0.
- a=0x0000, b=0x0001, bi=0 -> d=0xFFFF, bo=1, ovf=0. Then a=0x0005, b=0x0003, bi=1 -> d=0x0001, bo=0.
- a=0x8000, b=0x0001, bi=0 -> d=0x7FFF, ovf=1, bo=0. Then a=0x7FFF, b=0xFFFF -> d=0x8000, ovf=1, bo=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> d/bo/ovf stable and in_ready=0 throughout. Then out_ready=1 -> in_ready=1 on the following cycle; back-to-back operations show K+2 issue spacing.
- Pull rst_n low in the 2nd RUN cycle -> out_valid=0 and in_ready=1 immediately. After release, a new operation a=0x00FF, b=0x00FF gives d=0x0000, bo=0.
- Parameter sweep over (N,W) = (8,1), (8,8), (32,4) with 1000 random operands each -> d/bo/ovf match the reference model; latency = N/W.
